// File: rtl/rgb_to_bayer_if.sv
// Pixel bus between an RGB source and the rgb_to_bayer re-mosaicer.
// iPattern is present only when RGB2BAYER_PATSEL_EN is defined.
interface rgb_to_bayer_if #(
  parameter int DATA_W = 12
);
  logic              iFVAL;
  logic              iDVAL;
  logic [DATA_W-1:0] iRed;
  logic [DATA_W-1:0] iGreen;
  logic [DATA_W-1:0] iBlue;
`ifdef RGB2BAYER_PATSEL_EN
  logic [1:0]        iPattern;
`endif
  logic [DATA_W-1:0] oDATA;
  logic              oDVAL;
  logic              oFVAL;
  logic [10:0]       oX_Cont;
  logic [10:0]       oY_Cont;
  logic              oLINE_ERR;

  modport master (
    output iFVAL, iDVAL, iRed, iGreen, iBlue,
`ifdef RGB2BAYER_PATSEL_EN
    output iPattern,
`endif
    input  oDATA, oDVAL, oFVAL, oX_Cont, oY_Cont, oLINE_ERR
  );

  modport slave (
    input  iFVAL, iDVAL, iRed, iGreen, iBlue,
`ifdef RGB2BAYER_PATSEL_EN
    input  iPattern,
`endif
    output oDATA, oDVAL, oFVAL, oX_Cont, oY_Cont, oLINE_ERR
  );
endinterface

// File: rtl/rgb_to_bayer.sv
// Re-mosaics an RGB pixel stream into a raw Bayer stream with X/Y coordinates.
// Optional macro RGB2BAYER_PATSEL_EN adds a per-frame runtime Bayer phase select.
module rgb_to_bayer #(
  parameter int DATA_W        = 12,
  parameter int H_ACTIVE      = 1280,
  parameter int BAYER_PATTERN = 0
) (
  input  logic           iCLK,
  input  logic           iRST,
  rgb_to_bayer_if.slave  bus
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);

  state_t            state_q, state_d;
  logic              fval_p0, armed, line_err;
  logic              frame_start, frame_end, accept;
  logic [10:0]       x_cnt, y_cnt, cur_x, cur_y, next_x, next_y;
  logic [1:0]        cur_pat;
  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;
  logic [10:0]       x_p1, y_p1;

  // Component selection indexed by {pattern, Y[0], X[0]}
  function automatic logic [DATA_W-1:0] pick(input logic [1:0] pat, input logic [1:0] ph,
                                             input logic [DATA_W-1:0] r, g, b);
    case ({pat, ph})
      4'h1, 4'h4, 4'hB, 4'hE: pick = r;
      4'h2, 4'h7, 4'h8, 4'hD: pick = b;
      default:                pick = g;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state_q)
      IDLE: if (bus.iFVAL && !fval_p0 && armed) begin
        frame_start = 1'b1;
        state_d     = ACTIVE;
      end
      ACTIVE: if (!bus.iFVAL) begin
        frame_end = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = bus.iFVAL && bus.iDVAL && ((state_q == ACTIVE) || frame_start);
  assign cur_x  = frame_start ? 11'd0 : x_cnt;
  assign cur_y  = frame_start ? 11'd0 : y_cnt;
  assign next_x = (cur_x == X_LAST) ? 11'd0 : cur_x + 11'd1;
  assign next_y = (cur_x == X_LAST) ? cur_y + 11'd1 : cur_y;

`ifdef RGB2BAYER_PATSEL_EN
  logic [1:0] pat_q;
  assign cur_pat = frame_start ? bus.iPattern : pat_q;

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST)            pat_q <= 2'(BAYER_PATTERN);
    else if (frame_start) pat_q <= bus.iPattern;
  end
`else
  assign cur_pat = 2'(BAYER_PATTERN);
`endif

  // Stage p0 -> p1: frame tracking, counters and the registered output sample
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q  <= IDLE;
      fval_p0  <= 1'b0;
      armed    <= 1'b0;
      line_err <= 1'b0;
      x_cnt    <= '0;
      y_cnt    <= '0;
      vld_p1   <= 1'b0;
      data_p1  <= '0;
      x_p1     <= '0;
      y_p1     <= '0;
    end else begin
      state_q <= state_d;
      fval_p0 <= bus.iFVAL;
      // a frame already running at reset release must end before one is accepted
      if (!bus.iFVAL) armed <= 1'b1;
      if (frame_start)                     line_err <= 1'b0;
      else if (frame_end && x_cnt != '0)   line_err <= 1'b1;
      if (frame_end) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end else if (accept) begin
        x_cnt <= next_x;
        y_cnt <= next_y;
      end else if (frame_start) begin
        x_cnt <= '0;
        y_cnt <= '0;
      end
      vld_p1 <= accept;
      if (accept) begin
        data_p1 <= pick(cur_pat, {cur_y[0], cur_x[0]}, bus.iRed, bus.iGreen, bus.iBlue);
        x_p1    <= cur_x;
        y_p1    <= cur_y;
      end
    end
  end

  assign bus.oDATA     = data_p1;
  assign bus.oDVAL     = vld_p1;
  assign bus.oFVAL     = fval_p0;
  assign bus.oX_Cont   = x_p1;
  assign bus.oY_Cont   = y_p1;
  assign bus.oLINE_ERR = line_err;
endmodule

// File: tb/tb_rgb_to_bayer.sv
// Scoreboard bench for rgb_to_bayer: two instances (GRBG and RGGB) share one stimulus stream.
`timescale 1ns/1ps
module tb_rgb_to_bayer;
  localparam int DW = 12;
  localparam int HA = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rgb_to_bayer_if #(.DATA_W(DW)) b0 ();
  rgb_to_bayer_if #(.DATA_W(DW)) b1 ();

  rgb_to_bayer #(.DATA_W(DW), .H_ACTIVE(HA), .BAYER_PATTERN(0)) dut0 (
    .iCLK(clk), .iRST(rst_n), .bus(b0.slave));
  rgb_to_bayer #(.DATA_W(DW), .H_ACTIVE(HA), .BAYER_PATTERN(1)) dut1 (
    .iCLK(clk), .iRST(rst_n), .bus(b1.slave));

  assign b1.iFVAL  = b0.iFVAL;
  assign b1.iDVAL  = b0.iDVAL;
  assign b1.iRed   = b0.iRed;
  assign b1.iGreen = b0.iGreen;
  assign b1.iBlue  = b0.iBlue;
`ifdef RGB2BAYER_PATSEL_EN
  assign b1.iPattern = 2'd1;
`endif

  typedef struct {
    logic [DW-1:0] d;
    int            x;
    int            y;
    int            cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int tbx = 0;
  int tby = 0;
  logic [1:0] pat0 = 2'd0;
  // channel per pattern and phase {Y[0],X[0]}: 0=R 1=G 2=B (GRBG, RGGB, BGGR, GBRG)
  int chan [4][4] = '{'{1, 0, 2, 1}, '{0, 1, 1, 2}, '{2, 1, 1, 0}, '{1, 2, 0, 1}};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] col(input int c);
    return (c == 0) ? b0.iRed : (c == 1) ? b0.iGreen : b0.iBlue;
  endfunction

  always @(posedge clk) cyc++;

  task automatic mon(input int id);
    exp_t e;
    logic [DW-1:0] d;
    logic [10:0] x, y;
    d = (id == 0) ? b0.oDATA : b1.oDATA;
    x = (id == 0) ? b0.oX_Cont : b1.oX_Cont;
    y = (id == 0) ? b0.oY_Cont : b1.oY_Cont;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      tests++;
      fails++;
      $display("FAIL unexpected_dval dut%0d: got data %0h at (%0d,%0d) cycle %0d, required no sample",
               id, d, x, y, cyc);
    end else begin
      e = (id == 0) ? q0.pop_front() : q1.pop_front();
      check($sformatf("data dut%0d", id), 32'(d), 32'(e.d));
      check($sformatf("x dut%0d", id), 32'(x), e.x);
      check($sformatf("y dut%0d", id), 32'(y), e.y);
      check($sformatf("latency dut%0d", id), cyc, e.cyc);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (b0.oDVAL === 1'b1) mon(0);
    if (b1.oDVAL === 1'b1) mon(1);
  end

  // Drive one cycle's inputs (caller is at a negedge) and push expectations for accepted pixels.
  task automatic drive(input logic fv, input logic dv, input logic [DW-1:0] r, g, b);
    int ph;
    exp_t e;
    b0.iFVAL = fv;
    b0.iDVAL = dv;
    b0.iRed = r;
    b0.iGreen = g;
    b0.iBlue = b;
    if (!fv) begin
      tbx = 0;
      tby = 0;
    end else if (dv) begin
      ph = (tby % 2) * 2 + (tbx % 2);
      e.x = tbx;
      e.y = tby;
      e.cyc = cyc + 1;
      e.d = col(chan[pat0][ph]);
      q0.push_back(e);
      e.d = col(chan[1][ph]);
      q1.push_back(e);
      tbx++;
      if (tbx == HA) begin
        tbx = 0;
        tby++;
      end
    end
  endtask

  task automatic pix(input logic fv, input logic dv, input logic [DW-1:0] r, g, b);
    @(negedge clk);
    drive(fv, dv, r, g, b);
  endtask

  initial begin
    b0.iFVAL = 1'b0;
    b0.iDVAL = 1'b1;
    b0.iRed = '0;
    b0.iGreen = '0;
    b0.iBlue = '0;
`ifdef RGB2BAYER_PATSEL_EN
    b0.iPattern = 2'd0;
`endif
    // reset with iDVAL high and iFVAL low
    repeat (3) @(negedge clk);
    check("rst_data", 32'(b0.oDATA), 0);
    check("rst_dval", 32'(b0.oDVAL), 0);
    check("rst_fval", 32'(b0.oFVAL), 0);
    check("rst_x", 32'(b0.oX_Cont), 0);
    check("rst_y", 32'(b0.oY_Cont), 0);
    check("rst_err", 32'(b0.oLINE_ERR), 0);
    rst_n = 1'b1;
    repeat (3) pix(1'b0, 1'b1, 12'h111, 12'h222, 12'h333);
    @(negedge clk);
    check("idle_dval", 32'(b0.oDVAL), 0);

    // two full lines with constant colours
    for (int i = 0; i < 8; i++) begin
      pix(1'b1, 1'b1, 12'h111, 12'h222, 12'h333);
      if (i == 1) check("ofval_rise", 32'(b0.oFVAL), 1);
    end
    pix(1'b0, 1'b0, 12'h0, 12'h0, 12'h0);
    pix(1'b0, 1'b0, 12'h0, 12'h0, 12'h0);
    check("full_frame_err", 32'(b0.oLINE_ERR), 0);
    check("ofval_fall", 32'(b0.oFVAL), 0);

    // iDVAL gaps across 8 accepted pixels
    for (int i = 0; i < 16; i++)
      pix(1'b1, (i % 2) == 0, 12'(i + 1), 12'(i + 12'h100), 12'(i + 12'h200));
    pix(1'b0, 1'b0, 12'h0, 12'h0, 12'h0);
    pix(1'b0, 1'b0, 12'h0, 12'h0, 12'h0);

    // partial frame, then immediate restart with a frame-start pixel
    for (int i = 0; i < 6; i++) pix(1'b1, 1'b1, 12'h0A1, 12'h0B2, 12'h0C3);
    pix(1'b0, 1'b0, 12'h0, 12'h0, 12'h0);
    @(negedge clk);
    check("line_err_set", 32'(b0.oLINE_ERR), 1);
    drive(1'b1, 1'b1, 12'hABC, 12'h123, 12'h456);
    @(negedge clk);
    check("line_err_clr", 32'(b0.oLINE_ERR), 0);
    drive(1'b1, 1'b1, 12'h321, 12'h654, 12'h987);
    for (int i = 0; i < 2; i++) pix(1'b1, 1'b1, 12'h777, 12'h888, 12'h999);
    pix(1'b0, 1'b0, 12'h0, 12'h0, 12'h0);
    pix(1'b0, 1'b0, 12'h0, 12'h0, 12'h0);
    check("aligned_end_err", 32'(b0.oLINE_ERR), 0);

`ifdef RGB2BAYER_PATSEL_EN
    // runtime phase: BGGR latched at frame start, mid-frame change deferred
    @(negedge clk);
    b0.iPattern = 2'd2;
    pat0 = 2'd2;
    drive(1'b1, 1'b1, 12'h111, 12'h222, 12'h333);
    pix(1'b1, 1'b1, 12'h111, 12'h222, 12'h333);
    b0.iPattern = 2'd0;
    for (int i = 0; i < 6; i++) pix(1'b1, 1'b1, 12'h111, 12'h222, 12'h333);
    pix(1'b0, 1'b0, 12'h0, 12'h0, 12'h0);
    pat0 = 2'd0;
    for (int i = 0; i < 4; i++) pix(1'b1, 1'b1, 12'h111, 12'h222, 12'h333);
    pix(1'b0, 1'b0, 12'h0, 12'h0, 12'h0);
    pix(1'b0, 1'b0, 12'h0, 12'h0, 12'h0);
`endif

    // reset mid-frame; the frame still running at release must be ignored
    for (int i = 0; i < 3; i++) pix(1'b1, 1'b1, 12'h5A5, 12'h6B6, 12'h7C7);
    pix(1'b1, 1'b0, 12'h0, 12'h0, 12'h0);
    @(negedge clk);
    rst_n = 1'b0;
    tbx = 0;
    tby = 0;
    #1;
    check("midrst_fval", 32'(b0.oFVAL), 0);
    check("midrst_x", 32'(b0.oX_Cont), 0);
    check("midrst_data", 32'(b0.oDATA), 0);
    b0.iDVAL = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("ignored_frame_dval", 32'(b0.oDVAL), 0);
    drive(1'b0, 1'b0, 12'h0, 12'h0, 12'h0);
    for (int i = 0; i < 4; i++) pix(1'b1, 1'b1, 12'h135, 12'h246, 12'h357);
    pix(1'b0, 1'b0, 12'h0, 12'h0, 12'h0);
    repeat (3) @(negedge clk);

    check("q0_drained", q0.size(), 0);
    check("q1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
